// File: rtl/writeback_regfile.sv
// Y86-64 SEQ register file and write-back stage: two combinational read ports,
// E/M destination decode, sticky halt/error status and a retired-instruction counter.
module writeback_regfile #(
   parameter int NREGS  = 15,
   parameter int RSP_ID = 4,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_en,
   input  logic [3:0]       icode,
   input  logic             cnd,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic [63:0]      valE,
   input  logic [63:0]      valM,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [63:0]      valA,
   output logic [63:0]      valB,
   output logic [3:0]       dstE,
   output logic [3:0]       dstM,
   output logic             halted,
   output logic             inst_err,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] RNONE = 4'hF;

   logic [63:0]      regs_q [NREGS];
   logic [63:0]      regs_d [NREGS];
   logic             halted_q, halted_d;
   logic             inst_err_q, inst_err_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [3:0]       dst_e, dst_m;
   logic [63:0]      val_a, val_b;
   logic             accept;

   always_comb begin
      dst_e = RNONE;
      case (icode)
         4'h2:                      dst_e = cnd ? rB : RNONE;
         4'h3, 4'h6:                dst_e = rB;
         4'h8, 4'h9, 4'hA, 4'hB:    dst_e = 4'(RSP_ID);
         default:                   dst_e = RNONE;
      endcase
      dst_m = RNONE;
      if (icode == 4'h5 || icode == 4'hB) dst_m = rA;
   end

   // ID 15 matches no entry, so RNONE reads 0 and its writes fall away
   always_comb begin
      val_a = '0;
      val_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (srcA == 4'(i)) val_a = regs_q[i];
         if (srcB == 4'(i)) val_b = regs_q[i];
      end
   end

   always_comb begin
      accept     = wb_en && !halted_q && !inst_err_q;
      regs_d     = regs_q;
      halted_d   = halted_q;
      inst_err_d = inst_err_q;
      retired_d  = retired_q;
      if (accept) begin
         if (icode > 4'hB) begin
            inst_err_d = 1'b1;
         end else begin
            // M write follows E so it wins a same-register collision
            for (int i = 0; i < NREGS; i++) begin
               if (dst_e == 4'(i)) regs_d[i] = valE;
               if (dst_m == 4'(i)) regs_d[i] = valM;
            end
            retired_d = retired_q + CNT_W'(1);
            if (icode == 4'h0) halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         halted_q   <= 1'b0;
         inst_err_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         regs_q     <= regs_d;
         halted_q   <= halted_d;
         inst_err_q <= inst_err_d;
         retired_q  <= retired_d;
      end
   end

   assign valA     = val_a;
   assign valB     = val_b;
   assign dstE     = dst_e;
   assign dstM     = dst_m;
   assign halted   = halted_q;
   assign inst_err = inst_err_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus random
// instruction streams checked against an array-based architectural model.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        rst_n, wb_en, cnd;
   logic [3:0]  icode, rA, rB, srcA, srcB;
   logic [63:0] valE, valM;
   logic [63:0] valA, valB;
   logic [3:0]  dstE, dstM;
   logic        halted, inst_err;
   logic [31:0] retired;

   logic [63:0] s_valA, s_valB;
   logic [3:0]  s_dstE, s_dstM;
   logic        s_halted, s_inst_err;
   logic [7:0]  s_retired;

   int total = 0;
   int bad   = 0;

   logic [63:0] m_regs [16];
   int unsigned m_ret;
   logic        m_halt, m_err;

   always #5 clk = ~clk;

   writeback_regfile dut (
      .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .icode(icode), .cnd(cnd),
      .rA(rA), .rB(rB), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
      .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM),
      .halted(halted), .inst_err(inst_err), .retired(retired)
   );

   writeback_regfile #(.CNT_W(8)) dut_small (
      .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .icode(icode), .cnd(cnd),
      .rA(rA), .rB(rB), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
      .valA(s_valA), .valB(s_valB), .dstE(s_dstE), .dstM(s_dstM),
      .halted(s_halted), .inst_err(s_inst_err), .retired(s_retired)
   );

   function automatic logic [3:0] exp_dste(input logic [3:0] ic, input logic c, input logic [3:0] b);
      if (ic == 4'h2) return c ? b : 4'hF;
      if (ic inside {4'h3, 4'h6}) return b;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] exp_dstm(input logic [3:0] ic, input logic [3:0] a);
      if (ic inside {4'h5, 4'hB}) return a;
      return 4'hF;
   endfunction

   // Drive one instruction, clock it in, and advance the model.
   task automatic step(input logic [3:0] ic, input logic c, input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] e, input logic [63:0] m, input logic en, input logic rn);
      logic [3:0] de, dm;
      icode = ic; cnd = c; rA = a; rB = b; valE = e; valM = m; wb_en = en; rst_n = rn;
      @(posedge clk);
      #1;
      de = exp_dste(ic, c, b);
      dm = exp_dstm(ic, a);
      if (!rn) begin
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
         m_ret = 0; m_halt = 1'b0; m_err = 1'b0;
      end else if (en && !m_halt && !m_err) begin
         if (ic > 4'hB) m_err = 1'b1;
         else begin
            if (de != 4'hF) m_regs[de] = e;
            if (dm != 4'hF) m_regs[dm] = m;
            m_ret = m_ret + 1;
            if (ic == 4'h0) m_halt = 1'b1;
         end
      end
      wb_en = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_reset;
      step(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         srcA = 4'(i); srcB = 4'(15 - i); #1;
         total++;
         if (valA !== 64'd0 || valB !== 64'd0) begin
            bad++;
            $display("FAIL reset_read id=%0d valA=%h valB=%h want 0", i, valA, valB);
         end
      end
      total++;
      if (halted !== 1'b0 || inst_err !== 1'b0 || retired !== 32'd0) begin
         bad++;
         $display("FAIL reset_status halted=%b err=%b retired=%0d want 0 0 0", halted, inst_err, retired);
      end
   endtask

   task automatic test_irmovq;
      icode = 4'h3; rB = 4'd3; rA = 4'hF; valE = 64'h0123456789ABCDEF; srcA = 4'd3; #1;
      total++;
      if (valA !== 64'd0 || dstE !== 4'd3 || dstM !== 4'hF) begin
         bad++;
         $display("FAIL irmovq_pre valA=%h dstE=%h dstM=%h want 0 3 f", valA, dstE, dstM);
      end
      step(4'h3, 1'b0, 4'hF, 4'd3, 64'h0123456789ABCDEF, '0, 1'b1, 1'b1);
      srcA = 4'd3; #1;
      total++;
      if (valA !== 64'h0123456789ABCDEF || retired !== 32'd1) begin
         bad++;
         $display("FAIL irmovq_post valA=%h retired=%0d want 0123456789abcdef 1", valA, retired);
      end
   endtask

   task automatic test_cmov;
      icode = 4'h2; cnd = 1'b0; rB = 4'd2; #1;
      total++;
      if (dstE !== 4'hF) begin bad++; $display("FAIL cmov_dste_nc got=%h want f", dstE); end
      step(4'h2, 1'b0, 4'hF, 4'd2, 64'd5, '0, 1'b1, 1'b1);
      srcB = 4'd2; #1;
      total++;
      if (valB !== 64'd0 || retired !== 32'd2) begin
         bad++;
         $display("FAIL cmov_nc valB=%h retired=%0d want 0 2", valB, retired);
      end
      step(4'h2, 1'b1, 4'hF, 4'd2, 64'd5, '0, 1'b1, 1'b1);
      srcB = 4'd2; #1;
      total++;
      if (valB !== 64'd5 || retired !== 32'd3) begin
         bad++;
         $display("FAIL cmov_c valB=%h retired=%0d want 5 3", valB, retired);
      end
   endtask

   task automatic test_popq;
      icode = 4'hB; rA = 4'd4; #1;
      total++;
      if (dstE !== 4'd4 || dstM !== 4'd4) begin
         bad++;
         $display("FAIL popq_dst dstE=%h dstM=%h want 4 4", dstE, dstM);
      end
      step(4'hB, 1'b0, 4'd4, 4'hF, 64'h108, 64'h55, 1'b1, 1'b1);
      srcA = 4'd4; #1;
      total++;
      if (valA !== 64'h55) begin bad++; $display("FAIL popq_collide reg4=%h want 55", valA); end
      step(4'hB, 1'b0, 4'd1, 4'hF, 64'h110, 64'h77, 1'b1, 1'b1);
      srcA = 4'd4; srcB = 4'd1; #1;
      total++;
      if (valA !== 64'h110 || valB !== 64'h77) begin
         bad++;
         $display("FAIL popq_split reg4=%h reg1=%h want 110 77", valA, valB);
      end
   endtask

   task automatic test_random;
      logic [3:0]  ic, a, b;
      logic        c, en;
      logic [63:0] e, m;
      for (int n = 0; n < 300; n++) begin
         ic = 4'($urandom_range(1, 11));
         c  = 1'($urandom);
         a  = 4'($urandom_range(0, 15));
         b  = 4'($urandom_range(0, 15));
         e  = {$urandom, $urandom};
         m  = {$urandom, $urandom};
         en = ($urandom_range(0, 9) != 0);
         icode = ic; cnd = c; rA = a; rB = b;
         srcA = 4'($urandom_range(0, 15)); srcB = 4'($urandom_range(0, 15)); #1;
         total++;
         if (dstE !== exp_dste(ic, c, b) || dstM !== exp_dstm(ic, a) ||
             valA !== m_regs[srcA] || valB !== m_regs[srcB]) begin
            bad++;
            $display("FAIL rand_pre n=%0d dstE=%h dstM=%h valA=%h valB=%h want %h %h %h %h", n,
                     dstE, dstM, valA, valB, exp_dste(ic, c, b), exp_dstm(ic, a), m_regs[srcA], m_regs[srcB]);
         end
         step(ic, c, a, b, e, m, en, 1'b1);
         total++;
         if (retired !== m_ret) begin
            bad++;
            $display("FAIL rand_retired n=%0d got=%0d want %0d", n, retired, m_ret);
         end
      end
      for (int i = 0; i < 16; i++) begin
         srcA = 4'(i); #1;
         total++;
         if (valA !== m_regs[i]) begin
            bad++;
            $display("FAIL rand_final reg%0d got=%h want %h", i, valA, m_regs[i]);
         end
      end
   endtask

   task automatic test_halt;
      step(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b0, 1'b0);
      step(4'h3, 1'b0, 4'hF, 4'd7, 64'hABCD, '0, 1'b1, 1'b1);
      step(4'h0, 1'b0, 4'hF, 4'hF, '0, '0, 1'b1, 1'b1);
      step(4'h3, 1'b0, 4'hF, 4'd0, 64'd9, '0, 1'b1, 1'b1);
      srcA = 4'd0; srcB = 4'd7; #1;
      total++;
      if (halted !== 1'b1 || inst_err !== 1'b0 || retired !== 32'd2 || valA !== 64'd0 || valB !== 64'hABCD) begin
         bad++;
         $display("FAIL halt halted=%b err=%b retired=%0d reg0=%h reg7=%h want 1 0 2 0 abcd",
                  halted, inst_err, retired, valA, valB);
      end
   endtask

   task automatic test_inst_err;
      step(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b0, 1'b0);
      step(4'hC, 1'b0, 4'hF, 4'd0, 64'd3, '0, 1'b1, 1'b1);
      step(4'h3, 1'b0, 4'hF, 4'd0, 64'd9, '0, 1'b1, 1'b1);
      srcA = 4'd0; #1;
      total++;
      if (inst_err !== 1'b1 || halted !== 1'b0 || retired !== 32'd0 || valA !== 64'd0) begin
         bad++;
         $display("FAIL inst_err err=%b halted=%b retired=%0d reg0=%h want 1 0 0 0",
                  inst_err, halted, retired, valA);
      end
   endtask

   task automatic test_reset_mid;
      step(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b0, 1'b0);
      step(4'h3, 1'b0, 4'hF, 4'd9, 64'h1234, '0, 1'b1, 1'b1);
      step(4'h3, 1'b0, 4'hF, 4'd5, 64'hDEAD, '0, 1'b1, 1'b0);
      srcA = 4'd5; srcB = 4'd9; #1;
      total++;
      if (valA !== 64'd0 || valB !== 64'd0 || retired !== 32'd0 || halted !== 1'b0 || inst_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid reg5=%h reg9=%h retired=%0d halted=%b err=%b want all 0",
                  valA, valB, retired, halted, inst_err);
      end
   endtask

   task automatic test_wrap;
      step(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b0, 1'b0);
      for (int n = 0; n < 255; n++) step(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b1, 1'b1);
      total++;
      if (s_retired !== 8'hFF) begin bad++; $display("FAIL wrap_pre got=%h want ff", s_retired); end
      step(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b1, 1'b1);
      total++;
      if (s_retired !== 8'h00 || s_halted !== 1'b0 || s_inst_err !== 1'b0 || retired !== m_ret) begin
         bad++;
         $display("FAIL wrap small=%h halted=%b err=%b main=%0d want 00 0 0 %0d",
                  s_retired, s_halted, s_inst_err, retired, m_ret);
      end
   endtask

   initial begin
      rst_n = 1'b0; wb_en = 1'b0; icode = 4'h1; cnd = 1'b0; rA = 4'hF; rB = 4'hF;
      valE = '0; valM = '0; srcA = '0; srcB = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_ret = 0; m_halt = 1'b0; m_err = 1'b0;
      #2;
      test_reset;
      test_irmovq;
      test_cmov;
      test_popq;
      test_random;
      test_halt;
      test_inst_err;
      test_reset_mid;
      test_wrap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
